// File: rtl/fft_peak_detect_pkg.sv
// -----------------------------------------------------------------------------
// fft_peak_detect_pkg
// Shared constants, types and helpers for the FFT peak detector.
//   N / LOG2N        bins per frame and bin-index width
//   MUL_LAT/ADD_LAT  latency of the shared Mult and Adder cores
//   PIPE_LAT         total operand-to-sum1 latency carried by the tag pipe
//   FP_POS_INF       IEEE-754 single +Inf
//   FP_EXP_MASK      exponent field mask of an IEEE-754 single
//   state_t          detector FSM state encoding
//   tag_t            {valid, bin} tag travelling alongside the shared operators
// -----------------------------------------------------------------------------
package fft_peak_detect_pkg;

    localparam int N        = 256;
    localparam int LOG2N    = 8;
    localparam int MUL_LAT  = 6;
    localparam int ADD_LAT  = 7;
    localparam int PIPE_LAT = MUL_LAT + ADD_LAT;
    localparam int TAG_W    = LOG2N + 1;
    localparam int DRAIN_W  = $clog2(PIPE_LAT + 1);

    localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_EXP_MASK = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [LOG2N-1:0] bin;
    } tag_t;

    // NaN: exponent all ones with a non-zero mantissa.
    function automatic logic fp_is_nan(input logic [31:0] f);
        return ((f & FP_EXP_MASK) == FP_EXP_MASK) && (f[22:0] != 23'd0);
    endfunction

    // Magnitude-squared is non-negative, so {exp,mant} orders as an unsigned
    // integer; dropping the sign also makes -0 compare equal to +0.
    function automatic logic [30:0] fp_mag(input logic [31:0] f);
        return f[30:0];
    endfunction

endpackage

// File: rtl/fft_peak_detect_tag_delay.sv
// -----------------------------------------------------------------------------
// tag_delay
// Fixed-depth shift register carrying a tag alongside an external pipeline.
//   clk  rising-edge clock
//   rst  asynchronous active-high clear of every stage
//   d    tag entering the pipe this cycle
//   q    tag that entered DEPTH cycles ago
// -----------------------------------------------------------------------------
module tag_delay #(
    parameter int DEPTH = 13,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: this is a register chain rather than a RAM, so clearing every
    // stage on reset is cheap and is what guarantees an aborted frame leaves
    // no live tag behind to corrupt the next search.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/fft_peak_detect.sv
// -----------------------------------------------------------------------------
// fft_peak_detect
// Consumes one frame of N complex FFT bins (IEEE-754 single re/im), computes
// |X|^2 = re*re + im*im on the shared Mult/Adder cores and reports the index
// and value of the largest |X|^2 once per frame.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start / ready       frame request (sampled in IDLE) / high while IDLE
//   in_re, in_im        current bin, qualified by in_valid, order 0..N-1
//   m1,n1 / m2,n2       Mult1 (re,re) and Mult2 (im,im) operands
//   prod1, prod2        Mult results, MUL_LAT cycles after operands
//   a1, b1              Adder operands (pass-through of prod1/prod2)
//   sum1                Adder result, ADD_LAT cycles after a1/b1
//   peak_bin, peak_mag  result; updated only when a frame completes
//   valid               high from frame completion until next accepted start
//
// Build option
//   PEAK_SKIP_DC_EN     when defined, bin 0 (DC) is excluded from the search
// -----------------------------------------------------------------------------
module fft_peak_detect
    import fft_peak_detect_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [31:0]      in_re,
    input  logic [31:0]      in_im,
    input  logic             in_valid,
    output logic [31:0]      m1,
    output logic [31:0]      n1,
    output logic [31:0]      m2,
    output logic [31:0]      n2,
    input  logic [31:0]      prod1,
    input  logic [31:0]      prod2,
    output logic [31:0]      a1,
    output logic [31:0]      b1,
    input  logic [31:0]      sum1,
    output logic [LOG2N-1:0] peak_bin,
    output logic [31:0]      peak_mag,
    output logic             valid
);

`ifdef PEAK_SKIP_DC_EN
    localparam logic SKIP_DC = 1'b1;
`else
    localparam logic SKIP_DC = 1'b0;
`endif

    localparam logic [LOG2N-1:0]   LAST_BIN  = LOG2N'(N - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(PIPE_LAT);

    state_t             state;
    state_t             state_nx;
    logic [LOG2N-1:0]   bin_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [31:0]        re_q;
    logic [31:0]        im_q;
    tag_t               op_tag;
    tag_t               out_tag;
    logic [30:0]        max_mag;
    logic [LOG2N-1:0]   max_bin;
    logic               accept;
    logic               frame_start;
    logic               take;

    assign accept      = (state == ST_FEED) && in_valid;
    assign frame_start = (state == ST_IDLE) && start;
    assign ready       = (state == ST_IDLE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_FEED;
            ST_FEED:  if (accept && (bin_cnt == LAST_BIN)) state_nx = ST_DRAIN;
            // The drain covers the operand register plus the full operator
            // latency, so the last bin's compare happens on the exit edge.
            ST_DRAIN: if (drain_cnt == DRAIN_END) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- counters
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_cnt   <= '0;
                        drain_cnt <= '0;
                    end
                end
                ST_FEED:  if (accept) bin_cnt <= bin_cnt + 1'b1;
                ST_DRAIN: drain_cnt <= drain_cnt + 1'b1;
                default:  ;
            endcase
        end
    end

    // ------------------------------------------------ operand stage + tags
    // Operands are registered so the shared cores see a clean launch; idle
    // cycles drive zeros. The tag is registered alongside them and then
    // delayed by the operator latency so it lines up with sum1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q   <= '0;
            im_q   <= '0;
            op_tag <= '0;
        end else begin
            re_q         <= accept ? in_re : '0;
            im_q         <= accept ? in_im : '0;
            op_tag.valid <= accept && !(SKIP_DC && (bin_cnt == '0));
            op_tag.bin   <= bin_cnt;
        end
    end

    assign m1 = re_q;
    assign n1 = re_q;
    assign m2 = im_q;
    assign n2 = im_q;
    assign a1 = prod1;
    assign b1 = prod2;

    tag_delay #(
        .DEPTH (PIPE_LAT),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk (clk),
        .rst (rst),
        .d   (op_tag),
        .q   (out_tag)
    );

    // ------------------------------------------------------- running max
    // Strictly-greater update keeps the lowest bin on a tie; NaN never wins.
    assign take = out_tag.valid && !fp_is_nan(sum1) && (fp_mag(sum1) > max_mag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_mag <= '0;
            max_bin <= '0;
        end else if (frame_start) begin
            max_mag <= '0;
            max_bin <= '0;
        end else if (take) begin
            max_mag <= fp_mag(sum1);
            max_bin <= out_tag.bin;
        end
    end

    // ------------------------------------------------------------ result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_bin <= '0;
            peak_mag <= '0;
            valid    <= 1'b0;
        end else if (frame_start) begin
            valid <= 1'b0;
        end else if (state == ST_DONE) begin
            peak_bin <= max_bin;
            peak_mag <= {1'b0, max_mag};
            valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// -----------------------------------------------------------------------------
// tb_fft_peak_detect
// Drives frames into fft_peak_detect, models the shared Mult/Adder cores with
// real arithmetic, and checks peak_bin / peak_mag / latency through a
// scoreboard queue popped by an independent monitor on each rising valid.
// -----------------------------------------------------------------------------
module tb_fft_peak_detect;
    import fft_peak_detect_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             ready;
    logic [31:0]      in_re = '0;
    logic [31:0]      in_im = '0;
    logic             in_valid = 1'b0;
    logic [31:0]      m1, n1, m2, n2, a1, b1;
    logic [31:0]      prod1, prod2, sum1;
    logic [LOG2N-1:0] peak_bin;
    logic [31:0]      peak_mag;
    logic             valid;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [LOG2N-1:0] bin;
        logic [31:0]      mag;
        int               st;
        int               lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] fr_re [N];
    logic [31:0] fr_im [N];

    fft_peak_detect dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
        .m1(m1), .n1(n1), .m2(m2), .n2(n2),
        .prod1(prod1), .prod2(prod2), .a1(a1), .b1(b1), .sum1(sum1),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .valid(valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------- float helpers
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)      d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]);
        if (e == 2047) return {d[63], 8'hFF, (d[51:0] != 0) ? 23'h400000 : 23'h0};
        if (e == 0) return {d[63], 31'd0};
        e = e - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // ------------------------------------------ shared operator models
    logic [31:0] mp1 [MUL_LAT];
    logic [31:0] mp2 [MUL_LAT];
    logic [31:0] ap  [ADD_LAT];

    initial begin
        for (int i = 0; i < MUL_LAT; i++) begin mp1[i] = '0; mp2[i] = '0; end
        for (int i = 0; i < ADD_LAT; i++) ap[i] = '0;
    end

    always @(posedge clk) begin
        mp1[0] <= fmul(m1, n1);
        mp2[0] <= fmul(m2, n2);
        ap[0]  <= fadd(a1, b1);
        for (int i = 1; i < MUL_LAT; i++) begin
            mp1[i] <= mp1[i-1];
            mp2[i] <= mp2[i-1];
        end
        for (int i = 1; i < ADD_LAT; i++) ap[i] <= ap[i-1];
    end

    assign prod1 = mp1[MUL_LAT-1];
    assign prod2 = mp2[MUL_LAT-1];
    assign sum1  = ap[ADD_LAT-1];

    // ---------------------------------------------------- reference model
    task automatic ref_peak(output logic [LOG2N-1:0] bin, output logic [31:0] mag);
        logic [31:0] m;
        bin = '0;
        mag = '0;
        for (int i = 0; i < N; i++) begin
            m = fadd(fmul(fr_re[i], fr_re[i]), fmul(fr_im[i], fr_im[i]));
`ifdef PEAK_SKIP_DC_EN
            if (i == 0) continue;
`endif
            if (m[30:23] == 8'hFF && m[22:0] != 0) continue;
            if (m[30:0] > mag[30:0]) begin
                bin = LOG2N'(i);
                mag = {1'b0, m[30:0]};
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic logic [31:0] rand_f();
        if ($urandom_range(0, 3) == 0) return 32'h0;
        return {1'($urandom), 8'(110 + $urandom_range(0, 30)), 23'($urandom)};
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin fr_re[i] = '0; fr_im[i] = '0; end
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) begin fr_re[i] = rand_f(); fr_im[i] = rand_f(); end
    endtask

    // --------------------------------------------------------- driver
    // bubble_mode: 0 none, 1 every 3rd cycle, 2 random. abort_at >= 0 asserts
    // rst when that bin is due and pushes no expectation.
    task automatic run_frame(input int bubble_mode, input int abort_at, input bit use_model,
                             input logic [LOG2N-1:0] xbin, input logic [31:0] xmag);
        int w, b, c, bubbles, st;
        exp_t e;
        w = 0;
        while (!ready && w < 100) begin @(posedge clk); #1; w++; end
        check("ready_before_start", 64'(ready), 64'd1);
        start = 1'b1;
        st = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        b = 0; c = 0; bubbles = 0;
        while (b < N) begin
            if (abort_at >= 0 && b == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_ready", 64'(ready), 64'd1);
                check("abort_valid", 64'(valid), 64'd0);
                check("abort_peak_bin", 64'(peak_bin), 64'd0);
                check("abort_peak_mag", 64'(peak_mag), 64'd0);
                check("abort_m1", 64'(m1), 64'd0);
                @(posedge clk); #1;
                check("abort_hold_valid", 64'(valid), 64'd0);
                rst = 1'b0;
                in_valid = 1'b0;
                return;
            end
            if ((bubble_mode == 1 && c % 3 == 2) ||
                (bubble_mode == 2 && $urandom_range(0, 7) == 0)) begin
                in_valid = 1'b0;
                in_re = FP_POS_INF;
                in_im = FP_POS_INF;
                bubbles++;
            end else begin
                in_valid = 1'b1;
                in_re = fr_re[b];
                in_im = fr_im[b];
                b++;
            end
            c++;
            @(posedge clk); #1;
        end
        // Junk presented outside FEED must be ignored; +Inf would win if taken.
        in_valid = 1'b1;
        in_re = FP_POS_INF;
        in_im = FP_POS_INF;
        if (use_model) ref_peak(e.bin, e.mag);
        else begin e.bin = xbin; e.mag = xmag; end
        e.st  = st;
        e.lat = N + PIPE_LAT + 2 + bubbles;
        sb.push_back(e);
    endtask

    // --------------------------------------------------------- monitor
    initial begin
        logic valid_d;
        exp_t e;
        valid_d = 1'b0;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && valid_d !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("peak_bin", 64'(peak_bin), 64'(e.bin));
                    check("peak_mag", 64'(peak_mag), 64'(e.mag));
                    check("latency", 64'(cyc - e.st - 1), 64'(e.lat));
                end
            end
            valid_d = valid;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- stimulus
    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_peak_bin", 64'(peak_bin), 64'd0);
        check("rst_peak_mag", 64'(peak_mag), 64'd0);
        check("rst_operands", {m1, m2}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single tone: |3+4j|^2 = 25.0
        clear_frame();
        fr_re[37] = 32'h4040_0000; fr_im[37] = 32'h4080_0000;
        run_frame(0, -1, 1'b0, 8'd37, 32'h41C8_0000);

        // Tie keeps the lowest bin
        clear_frame();
        fr_re[10] = 32'h3F80_0000; fr_re[200] = 32'h3F80_0000;
        run_frame(0, -1, 1'b0, 8'd10, 32'h3F80_0000);

        // DC dominant
        clear_frame();
        fr_re[0] = 32'h4100_0000;
        fr_re[5] = 32'h3F80_0000; fr_im[5] = 32'h3F80_0000;
`ifdef PEAK_SKIP_DC_EN
        run_frame(0, -1, 1'b0, 8'd5, 32'h4000_0000);
`else
        run_frame(0, -1, 1'b0, 8'd0, 32'h4280_0000);
`endif

        // Bubbles every third cycle, tone at the last bin
        clear_frame();
        fr_im[255] = 32'hC000_0000;
        run_frame(1, -1, 1'b0, 8'd255, 32'h4080_0000);

        // All-zero frame
        clear_frame();
        run_frame(0, -1, 1'b0, 8'd0, 32'h0);

        // Reset mid-frame, then a fresh frame
        random_frame();
        run_frame(0, 100, 1'b0, 8'd0, 32'h0);
        clear_frame();
        fr_re[3] = 32'h4000_0000;
        run_frame(0, -1, 1'b0, 8'd3, 32'h4080_0000);

        // NaN is skipped, +Inf wins
        clear_frame();
        fr_re[7] = 32'h7FC0_0000;
        fr_re[9] = FP_POS_INF;
        fr_re[1] = 32'h3F80_0000;
        run_frame(0, -1, 1'b0, 8'd9, 32'h7F80_0000);

        // Randomised frames against the reference model
        for (int k = 0; k < 5; k++) begin
            random_frame();
            if (k == 2) begin
                logic [LOG2N-1:0] mb;
                logic [31:0] mm;
                ref_peak(mb, mm);
                // Duplicate the peak into a later bin to exercise the tie rule.
                fr_re[N-1] = fr_re[mb];
                fr_im[N-1] = fr_im[mb];
            end
            run_frame(2, -1, 1'b1, '0, '0);
        end

        in_valid = 1'b0;
        w = 0;
        while (sb.size() != 0 && w < 2000) begin @(posedge clk); w++; end
        repeat (2) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
